// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: hsync/vsync/data-enable/coordinates, one-cycle registered latency.
// Optional colour-bar source for bring-up when VGA_TESTPAT_EN is defined; otherwise rgb_out is constant zero.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          color_en_out,
    output logic [CW-1:0] x_out,
    output logic [CW-1:0] y_out,
    output logic          line_start_out,
    output logic          frame_start_out,
    output logic [11:0]   rgb_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON  = HS_POL[0];
    localparam logic          VS_ON  = VS_POL[0];

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          hs_p0;
    logic          vs_p0;
    logic          de_p0;
    logic          ls_p0;
    logic          fs_p0;

    always_comb begin
        hs_p0 = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_p0 = (vcnt >= VS_BEG) && (vcnt < VS_END);
        de_p0 = (hcnt < H_ACT) && (vcnt < V_ACT);
        ls_p0 = (hcnt == '0);
        fs_p0 = (hcnt == '0) && (vcnt == '0);
    end

    // Stage boundary: decoded counter state becomes the registered output set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt            <= '0;
            vcnt            <= '0;
            hsync_out       <= ~HS_ON;
            vsync_out       <= ~VS_ON;
            color_en_out    <= 1'b0;
            x_out           <= '0;
            y_out           <= '0;
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end else if (pix_en) begin
            hcnt <= (hcnt == H_LAST) ? '0 : hcnt + CW'(1);
            if (hcnt == H_LAST)
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
            hsync_out       <= hs_p0 ? HS_ON : ~HS_ON;
            vsync_out       <= vs_p0 ? VS_ON : ~VS_ON;
            color_en_out    <= de_p0;
            x_out           <= de_p0 ? hcnt : '0;
            y_out           <= de_p0 ? vcnt : '0;
            line_start_out  <= ls_p0;
            frame_start_out <= fs_p0;
        end else begin
            // Idle strobe: everything holds except the start pulses, which must stay one cycle wide
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end
    end

`ifdef VGA_TESTPAT_EN
    // Bar index = floor(hcnt*8/H_ACTIVE), found by comparing hcnt*8 against constant multiples of H_ACTIVE
    function automatic logic [2:0] bar_idx(input logic [CW-1:0] h);
        logic [CW+2:0] h8;
        logic [2:0]    b;
        h8 = {h, 3'b000};
        b  = 3'd0;
        for (int k = 1; k < 8; k++)
            if (h8 >= (CW+3)'(k * H_ACTIVE)) b = b + 3'd1;
        return b;
    endfunction

    // White, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [11:0] bar_rgb(input logic [2:0] b);
        logic r, g, bl;
        r  = ~b[1];
        g  = ~b[2];
        bl = ~b[0];
        return {{4{r}}, {4{g}}, {4{bl}}};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rgb_out <= 12'h000;
        else if (pix_en)
            rgb_out <= de_p0 ? bar_rgb(bar_idx(hcnt)) : 12'h000;
    end
`else
    assign rgb_out = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen: three parameter sets checked against a pixel-index raster model.
module tb_vga_timing_gen;

    localparam int ND = 3;
    localparam int HA [ND] = '{800, 640, 16};
    localparam int HF [ND] = '{56, 16, 2};
    localparam int HS [ND] = '{120, 96, 4};
    localparam int HB [ND] = '{64, 48, 3};
    localparam int VA [ND] = '{600, 480, 10};
    localparam int VF [ND] = '{37, 10, 2};
    localparam int VS [ND] = '{6, 2, 2};
    localparam int VB [ND] = '{23, 33, 3};
    localparam int HP [ND] = '{1, 0, 0};
    localparam int VP [ND] = '{1, 0, 1};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b1;
    always #5 clk = ~clk;

    logic        hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1, hs2, vs2, de2, ls2, fs2;
    logic [10:0] x0, y0, x1, y1;
    logic [4:0]  x2, y2;
    logic [11:0] rgb0, rgb1, rgb2;

    vga_timing_gen dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_out(hs0), .vsync_out(vs0),
        .color_en_out(de0), .x_out(x0), .y_out(y0), .line_start_out(ls0),
        .frame_start_out(fs0), .rgb_out(rgb0));

    vga_timing_gen #(.H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
                     .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
                     .HS_POL(HP[1]), .VS_POL(VP[1]), .CW(11)) dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_out(hs1), .vsync_out(vs1),
        .color_en_out(de1), .x_out(x1), .y_out(y1), .line_start_out(ls1),
        .frame_start_out(fs1), .rgb_out(rgb1));

    vga_timing_gen #(.H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
                     .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
                     .HS_POL(HP[2]), .VS_POL(VP[2]), .CW(5)) dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_out(hs2), .vsync_out(vs2),
        .color_en_out(de2), .x_out(x2), .y_out(y2), .line_start_out(ls2),
        .frame_start_out(fs2), .rgb_out(rgb2));

    out_t act [ND];
    assign act[0] = {hs0, vs0, de0, x0, y0, ls0, fs0, rgb0};
    assign act[1] = {hs1, vs1, de1, x1, y1, ls1, fs1, rgb1};
    assign act[2] = {hs2, vs2, de2, 6'b0, x2, 6'b0, y2, ls2, fs2, rgb2};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    out_t q0[$];
    out_t q1[$];
    out_t q2[$];

    function automatic out_t reset_out(int d);
        out_t o;
        o    = '0;
        o.hs = (HP[d] == 0);
        o.vs = (VP[d] == 0);
        return o;
    endfunction

    // Expected outputs for linear raster position p of parameter set d
    function automatic out_t model_out(int d, int p);
        out_t o;
        int   ht, h, v;
        bit   hact, vact;
        ht   = HA[d] + HF[d] + HS[d] + HB[d];
        h    = p % ht;
        v    = p / ht;
        o    = '0;
        hact = (h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d]);
        vact = (v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d]);
        o.hs = hact ? (HP[d] != 0) : (HP[d] == 0);
        o.vs = vact ? (VP[d] != 0) : (VP[d] == 0);
        o.de = (h < HA[d]) && (v < VA[d]);
        o.x  = o.de ? 11'(h) : 11'd0;
        o.y  = o.de ? 11'(v) : 11'd0;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
`ifdef VGA_TESTPAT_EN
        begin
            logic [11:0] bars [8];
            bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
            o.rgb = o.de ? bars[(h * 8) / HA[d]] : 12'h000;
        end
`endif
        return o;
    endfunction

    function automatic int frame_len(int d);
        return (HA[d] + HF[d] + HS[d] + HB[d]) * (VA[d] + VF[d] + VS[d] + VB[d]);
    endfunction

    task automatic sb_push(int d, out_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: samples the inputs on every active edge and queues the expected output set
    int   pos  [ND];
    out_t last [ND];
    initial begin
        for (int d = 0; d < ND; d++) begin
            pos[d]  = 0;
            last[d] = reset_out(d);
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < ND; d++) begin
                out_t e;
                if (!rst) begin
                    pos[d] = 0;
                    e      = reset_out(d);
                end else if (pix_en) begin
                    e      = model_out(d, pos[d]);
                    pos[d] = (pos[d] + 1) % frame_len(d);
                end else begin
                    e    = last[d];
                    e.ls = 1'b0;
                    e.fs = 1'b0;
                end
                last[d] = e;
                sb_push(d, e);
            end
        end
    end

    // Monitor: pops one expected set per DUT per output cycle
    bit cnt_en = 1'b0;
    int cnt_hs = 0, cnt_de = 0, cnt_ls = 0, cnt_fs = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int d = 0; d < ND; d++) begin
                out_t e;
                int   sz;
                sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
                n_checks++;
                if (sz == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty dut%0d cycle %0d: no expected entry queued", d, cyc);
                end else begin
                    e = (d == 0) ? q0.pop_front() : (d == 1) ? q1.pop_front() : q2.pop_front();
                    if (act[d] !== e) begin
                        n_fail++;
                        $display("FAIL sb_dut%0d cycle %0d: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rgb=%h",
                                 d, cyc, act[d].hs, act[d].vs, act[d].de, act[d].x, act[d].y, act[d].ls, act[d].fs, act[d].rgb,
                                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.rgb);
                    end
                end
            end
            if (cnt_en) begin
                cnt_hs += int'(hs0);
                cnt_de += int'(de0);
                cnt_ls += int'(ls0);
                cnt_fs += int'(fs0);
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("async_rst_dut%0d", d), int'(act[d]), int'(reset_out(d)));
        @(negedge clk);
        rst    = 1'b1;
        pix_en = 1'b1;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_hsync0", int'(hs0), 0);
        chk("rst_vsync0", int'(vs0), 0);
        chk("rst_de0", int'(de0), 0);
        chk("rst_x0", int'(x0), 0);
        chk("rst_y0", int'(y0), 0);
        chk("rst_hsync1_lowpol", int'(hs1), 1);
        chk("rst_rgb0", int'(rgb0), 0);

        // Three full 1040-clock lines with pix_en held high
        rst    = 1'b1;
        cnt_en = 1'b1;
        repeat (3 * 1040) @(negedge clk);
        cnt_en = 1'b0;
        chk("hsync_high_3lines", cnt_hs, 3 * 120);
        chk("de_high_3lines", cnt_de, 3 * 800);
        chk("line_starts_3lines", cnt_ls, 3);
        chk("frame_starts_3lines", cnt_fs, 1);

        // Alternating strobe stretches all timing by two
        for (int i = 0; i < 2 * 2 * 1040; i++) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end

        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        pix_en = 1'b1;
        repeat ($urandom_range(200, 1500)) @(negedge clk);
        pulse_reset();

        // Enough continuous run for several small frames and their vsync windows
        for (int i = 0; i < 2500; i++) begin
            pix_en = ($urandom_range(0, 7) != 0);
            @(negedge clk);
        end
        pix_en = 1'b1;
        repeat (1200) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
